cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback around the decoder.
//  Consumes the decoder's 1-bit class flags; drives IR latch, PC update, regfile write and memory handshakes.
//  Provides halt detection and a memory-timeout bus error.
// PARAMETERS
//  MEM_WAIT_MAX  16  max consecutive req cycles without ack before ERR; 0 = no timeout
// PORTS
//  clk           in   1   system clock, single domain
//  rst           in   1   synchronous, active-high reset
//  imem_req      out  1   instruction fetch request
//  imem_ack      in   1   instruction word valid this cycle
//  ir_we         out  1   latch instruction register (1-cycle pulse)
//  dec_is_load   in   1   decoder: load instruction
//  dec_is_store  in   1   decoder: store instruction
//  dec_is_halt   in   1   decoder: halt instruction
//  dec_reg_we    in   1   decoder: instruction writes rd
//  take_target   in   1   ALU/branch unit: next PC = target (taken branch, JAL, JALR)
//  dmem_req      out  1   data memory request
//  dmem_we       out  1   data memory write (valid with dmem_req)
//  dmem_ack      in   1   data access complete this cycle
//  rf_we         out  1   register file write enable (1-cycle pulse)
//  pc_we         out  1   PC update (1-cycle pulse; one per retired instruction)
//  pc_src        out  1   0 = PC+4, 1 = target; valid with pc_we
//  halted        out  1   sticky, HALT state
//  bus_error     out  1   sticky, ERR state
//  state_dbg     out  3   current state encoding
//  cycle_cnt     out  32  see CONFIGURATION
//  instret_cnt   out  32  see CONFIGURATION
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERR=6; 7 unused -> ERR next cycle.
//  rst=1: state<=FETCH, wait counter<=0, counters<=0; all outputs 0 while rst high (incl. imem_req).
//  FETCH: imem_req=1. On imem_ack: ir_we=1 same cycle, -> DECODE. Otherwise stay.
//  DECODE: 1 cycle. dec_is_halt -> HALT. dec_is_load & dec_is_store -> ERR. Else -> EXEC.
//  EXEC: 1 cycle (ALU settles). Load or store -> MEM. Else -> WB.
//  MEM: dmem_req=1, dmem_we=dec_is_store, held constant until dmem_ack.
//   Load ack: -> WB.
//   Store ack: pc_we=1, pc_src=0 same cycle, -> FETCH.
//  WB: rf_we=dec_reg_we, pc_we=1, pc_src=take_target; -> FETCH.
//  HALT / ERR: absorbing until rst. All strobes 0. halted / bus_error = 1.
//  Outputs: Moore on state, except ir_we and the store-commit pc_we/pc_src, which also require the ack.
//  Decoder inputs read combinationally from the latched IR. Stable from DECODE through commit.
//  Timeout:
//   Wait counter increments on each FETCH/MEM cycle with req=1 and ack=0; clears on any state change.
//   An ack on the MEM_WAIT_MAX-th req cycle is accepted.
//   Otherwise, once MEM_WAIT_MAX req cycles pass without ack, -> ERR.
//  Ack outside FETCH/MEM: ignored. imem_ack in MEM and dmem_ack in FETCH: ignored.
//  Latency at zero-wait memory: ALU/branch/jump 4 cycles; load 5 cycles; store 4 cycles (no WB).
// CONFIGURATION
//  CPU_SEQ_PERF_CNT_EN defined:
//   cycle_cnt increments on every non-rst cycle outside HALT/ERR.
//   instret_cnt increments on every pc_we pulse.
//   Both 32-bit, wrap 0xFFFFFFFF->0, cleared by rst, frozen in HALT/ERR.
//  Not defined: no counter logic; cycle_cnt = instret_cnt = 32'd0.
// TESTING
//  1. ALU op, ack same cycle as req:
//     ir_we @1, rf_we/pc_we @4 with pc_src=0; imem_req again @5; instret_cnt=1.
//  2. Load, dmem_ack after 3 wait cycles:
//     dmem_req high 4 cycles with dmem_we=0; rf_we 1 cycle after ack.
//  3. Store, immediate ack:
//     dmem_we=1; pc_we with ack, pc_src=0; rf_we never asserted; next state FETCH.
//  4. Taken branch (dec_reg_we=0, take_target=1):
//     WB gives pc_we=1, pc_src=1, rf_we=0.
//  5. MEM_WAIT_MAX=4, imem_ack held 0:
//     ERR after 4 req cycles; bus_error=1 sticky; rst then returns to FETCH.
//     Ack on the 4th cycle proceeds normally.
//  6. dec_is_halt:
//     DECODE -> HALT; halted=1; acks ignored.
//     rst mid-MEM: dmem_req drops while rst is high; FETCH restarts after.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: handshake, decoder-flag and status bundle between the
// multi-cycle sequencer and the rest of the RV32I core.
//   slave  - sequencer side (drives strobes, requests and status)
//   master - core/memory side (drives acks and decoder class flags)
interface cpu_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_we;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_is_halt;
    logic        dec_reg_we;
    logic        take_target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic        pc_we;
    logic        pc_src;
    logic        halted;
    logic        bus_error;
    logic [2:0]  state_dbg;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport slave (
        input  imem_ack, dec_is_load, dec_is_store, dec_is_halt, dec_reg_we,
               take_target, dmem_ack,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src,
               halted, bus_error, state_dbg, cycle_cnt, instret_cnt
    );

    modport master (
        output imem_ack, dec_is_load, dec_is_store, dec_is_halt, dec_reg_we,
               take_target, dmem_ack,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src,
               halted, bus_error, state_dbg, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the
// RV32I core, with sticky HALT and a memory-timeout ERR state.
// Optional performance counters are built when CPU_SEQ_PERF_CNT_EN is defined;
// otherwise cycle_cnt and instret_cnt are tied to zero.
//
//   state  | code | meaning
//   FETCH  | 0    | imem_req high; ack latches IR
//   DECODE | 1    | decoder settles; halt / illegal load+store detected
//   EXEC   | 2    | ALU settles; choose MEM or WB
//   MEM    | 3    | dmem_req high until ack; store commits PC here
//   WB     | 4    | register write and PC update
//   HALT   | 5    | absorbing until rst
//   ERR    | 6    | absorbing until rst (timeout or illegal decode)
//   (7)    | 7    | unused, forced to ERR
module cpu_sequencer #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    // Wait counter only needs to count 0 .. MEM_WAIT_MAX-1.
    localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WW-1:0] WAIT_LAST =
        (MEM_WAIT_MAX > 0) ? WW'(MEM_WAIT_MAX - 1) : '0;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;

    logic imem_req_c;
    logic ir_we_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic rf_we_c;
    logic pc_we_c;
    logic pc_src_c;
    logic timeout_c;

    // A request has been pending for MEM_WAIT_MAX cycles including this one.
    assign timeout_c = (MEM_WAIT_MAX != 0) && (wait_q == WAIT_LAST);

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_src_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                end else if (MEM_WAIT_MAX != 0) begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: begin
                if (bus.dec_is_halt) begin
                    state_d = S_HALT;
                end else if (bus.dec_is_load && bus.dec_is_store) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.dec_is_load || bus.dec_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = bus.dec_is_store;
                if (bus.dmem_ack) begin
                    if (bus.dec_is_store) begin
                        // Stores retire here; there is no WB cycle.
                        pc_we_c  = 1'b1;
                        pc_src_c = 1'b0;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_c) begin
                    state_d = S_ERR;
                end else if (MEM_WAIT_MAX != 0) begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                rf_we_c  = bus.dec_reg_we;
                pc_we_c  = 1'b1;
                pc_src_c = bus.take_target;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // Every output is forced low while rst is asserted, even before the
    // first reset edge has cleared the state register.
    assign bus.imem_req  = imem_req_c & ~rst;
    assign bus.ir_we     = ir_we_c    & ~rst;
    assign bus.dmem_req  = dmem_req_c & ~rst;
    assign bus.dmem_we   = dmem_we_c  & ~rst;
    assign bus.rf_we     = rf_we_c    & ~rst;
    assign bus.pc_we     = pc_we_c    & ~rst;
    assign bus.pc_src    = pc_src_c   & ~rst;
    assign bus.halted    = (state_q == S_HALT) & ~rst;
    assign bus.bus_error = (state_q == S_ERR)  & ~rst;
    assign bus.state_dbg = rst ? 3'd0 : state_q;

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;
    logic        running_c;

    assign running_c = (state_q != S_HALT) && (state_q != S_ERR);
    assign cycle_d   = running_c ? cycle_q + 32'd1 : cycle_q;
    assign instret_d = pc_we_c ? instret_q + 32'd1 : instret_q;

    // Free-running cycle and retired-instruction counters, frozen in HALT/ERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign bus.cycle_cnt   = rst ? 32'd0 : cycle_q;
    assign bus.instret_cnt = rst ? 32'd0 : instret_q;
`else
    assign bus.cycle_cnt   = 32'd0;
    assign bus.instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed cycle vectors for the documented corner cases,
// followed by randomized instruction streams checked against a
// per-instruction timeline model.
module tb_cpu_sequencer;

    logic clk;
    logic rst;

    cpu_sequencer_if bus();

    cpu_sequencer #(.MEM_WAIT_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  in;
        logic [11:0] exp;
        string       nm;
    } vec_t;

    vec_t tv[$];

    int checks = 0;
    int passes = 0;
    int cyc_m  = 0;
    int ins_m  = 0;

    // Inputs: {rst, imem_ack, dmem_ack, load, store, halt, reg_we, take}
    function automatic logic [7:0] iv(input logic r, input logic ia,
                                      input logic da, input logic ld,
                                      input logic sto, input logic hl,
                                      input logic rw, input logic tk);
        return {r, ia, da, ld, sto, hl, rw, tk};
    endfunction

    // Outputs: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src,
    //           halted, bus_error, state[2:0]}
    function automatic logic [11:0] o(input logic ireq, input logic irwe,
                                      input logic dreq, input logic dwe,
                                      input logic rfwe, input logic pcwe,
                                      input logic pcsrc, input logic [2:0] st);
        return {ireq, irwe, dreq, dwe, rfwe, pcwe, pcsrc,
                (st == 3'd5), (st == 3'd6), st};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic [7:0] in, input logic [11:0] exp,
                                input string nm);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.nm  = nm;
        tv.push_back(v);
    endfunction

    task automatic step(input logic [7:0] in, input logic [11:0] exp,
                        input string nm);
        logic [11:0] act;
        logic [31:0] e_cyc;
        logic [31:0] e_ins;
        @(posedge clk);
        #1;
        {rst, bus.imem_ack, bus.dmem_ack, bus.dec_is_load, bus.dec_is_store,
         bus.dec_is_halt, bus.dec_reg_we, bus.take_target} = in;
        #1;
        act = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we,
               bus.pc_we, bus.pc_src, bus.halted, bus.bus_error, bus.state_dbg};
`ifdef CPU_SEQ_PERF_CNT_EN
        e_cyc = in[7] ? 32'd0 : 32'(cyc_m);
        e_ins = in[7] ? 32'd0 : 32'(ins_m);
`else
        e_cyc = 32'd0;
        e_ins = 32'd0;
`endif
        checks++;
        if (act === exp && bus.cycle_cnt === e_cyc && bus.instret_cnt === e_ins) begin
            passes++;
        end else begin
            $display("FAIL %s @%0t: outputs=%b cyc=%0d ins=%0d, expected outputs=%b cyc=%0d ins=%0d",
                     nm, $time, act, bus.cycle_cnt, bus.instret_cnt, exp, e_cyc, e_ins);
        end
        if (in[7]) begin
            cyc_m = 0;
            ins_m = 0;
        end else begin
            if (exp[2:0] != 3'd5 && exp[2:0] != 3'd6) cyc_m++;
            if (exp[6]) ins_m++;
        end
    endtask

    initial begin
        logic [11:0] zero_o;
        rst              = 1'b1;
        bus.imem_ack     = 1'b0;
        bus.dmem_ack     = 1'b0;
        bus.dec_is_load  = 1'b0;
        bus.dec_is_store = 1'b0;
        bus.dec_is_halt  = 1'b0;
        bus.dec_reg_we   = 1'b0;
        bus.take_target  = 1'b0;
        zero_o = o(0, 0, 0, 0, 0, 0, 0, 3'd0);

        // Reset, including strobes forced low while rst is high.
        add(iv(1, 1, 1, 0, 0, 0, 0, 0), zero_o, "reset0");
        add(iv(1, 0, 0, 0, 0, 0, 0, 0), zero_o, "reset1");
        // ALU op, zero-wait fetch.
        add(iv(0, 1, 0, 0, 0, 0, 1, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "alu_fetch");
        add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "alu_decode");
        add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "alu_exec");
        add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(0, 0, 0, 0, 1, 1, 0, 3'd4), "alu_wb");
        // Store, immediate ack, commits in MEM.
        add(iv(0, 1, 0, 0, 1, 0, 0, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "st_fetch");
        add(iv(0, 0, 0, 0, 1, 0, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "st_decode");
        add(iv(0, 0, 0, 0, 1, 0, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "st_exec");
        add(iv(0, 0, 1, 0, 1, 0, 1, 0), o(0, 0, 1, 1, 0, 1, 0, 3'd3), "st_mem_ack");
        // Taken branch.
        add(iv(0, 0, 0, 0, 0, 0, 0, 1), o(1, 0, 0, 0, 0, 0, 0, 3'd0), "br_fetch_wait");
        add(iv(0, 1, 0, 0, 0, 0, 0, 1), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "br_fetch");
        add(iv(0, 0, 0, 0, 0, 0, 0, 1), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "br_decode");
        add(iv(0, 0, 0, 0, 0, 0, 0, 1), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "br_exec");
        add(iv(0, 0, 0, 0, 0, 0, 0, 1), o(0, 0, 0, 0, 0, 1, 1, 3'd4), "br_wb");
        // Load with 3 wait cycles; ack on the 4th req cycle is accepted.
        add(iv(0, 1, 0, 1, 0, 0, 1, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "ld_fetch");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "ld_decode");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "ld_exec");
        for (int k = 0; k < 3; k++)
            add(iv(0, 1, 0, 1, 0, 0, 1, 0), o(0, 0, 1, 0, 0, 0, 0, 3'd3), "ld_mem_wait");
        add(iv(0, 0, 1, 1, 0, 0, 1, 0), o(0, 0, 1, 0, 0, 0, 0, 3'd3), "ld_mem_ack");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 1, 1, 0, 3'd4), "ld_wb");
        // Load whose data access never completes.
        add(iv(0, 1, 0, 1, 0, 0, 1, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "ldto_fetch");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "ldto_decode");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "ldto_exec");
        for (int k = 0; k < 4; k++)
            add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 1, 0, 0, 0, 0, 3'd3), "ldto_mem_wait");
        add(iv(0, 1, 1, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd6), "ldto_err");
        add(iv(0, 1, 1, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd6), "ldto_sticky");
        add(iv(1, 0, 0, 0, 0, 0, 0, 0), zero_o, "ldto_rst");
        // Fetch timeout; dmem_ack in FETCH is ignored.
        for (int k = 0; k < 4; k++)
            add(iv(0, 0, 1, 0, 0, 0, 0, 0), o(1, 0, 0, 0, 0, 0, 0, 3'd0), "fto_wait");
        add(iv(0, 1, 0, 0, 0, 0, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd6), "fto_err");
        add(iv(0, 1, 1, 0, 0, 0, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd6), "fto_sticky");
        add(iv(1, 0, 0, 0, 0, 0, 0, 0), zero_o, "fto_rst");
        // Fetch ack on the 4th req cycle proceeds.
        for (int k = 0; k < 3; k++)
            add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(1, 0, 0, 0, 0, 0, 0, 3'd0), "f4_wait");
        add(iv(0, 1, 0, 0, 0, 0, 1, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "f4_ack");
        add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "f4_decode");
        add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "f4_exec");
        add(iv(0, 0, 0, 0, 0, 0, 1, 0), o(0, 0, 0, 0, 1, 1, 0, 3'd4), "f4_wb");
        // Illegal load+store decode.
        add(iv(0, 1, 0, 0, 0, 0, 0, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "ldst_fetch");
        add(iv(0, 0, 0, 1, 1, 0, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "ldst_decode");
        add(iv(0, 1, 1, 1, 1, 0, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd6), "ldst_err");
        add(iv(1, 0, 0, 0, 0, 0, 0, 0), zero_o, "ldst_rst");
        // Halt: sticky, acks ignored.
        add(iv(0, 1, 0, 0, 0, 0, 0, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "halt_fetch");
        add(iv(0, 0, 0, 0, 0, 1, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "halt_decode");
        add(iv(0, 1, 1, 0, 0, 1, 0, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd5), "halted");
        add(iv(0, 1, 1, 0, 1, 0, 1, 1), o(0, 0, 0, 0, 0, 0, 0, 3'd5), "halted_sticky");
        add(iv(1, 0, 0, 0, 0, 0, 0, 0), zero_o, "halt_rst");
        add(iv(0, 0, 0, 0, 0, 0, 0, 0), o(1, 0, 0, 0, 0, 0, 0, 3'd0), "halt_restart");
        // Reset in the middle of a load's MEM phase.
        add(iv(0, 1, 0, 1, 0, 0, 1, 0), o(1, 1, 0, 0, 0, 0, 0, 3'd0), "mr_fetch_ack");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd1), "mr_decode");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 0, 0, 0, 0, 0, 3'd2), "mr_exec");
        add(iv(0, 0, 0, 1, 0, 0, 1, 0), o(0, 0, 1, 0, 0, 0, 0, 3'd3), "mr_mem");
        add(iv(1, 0, 1, 1, 0, 0, 1, 0), zero_o, "mr_rst");
        add(iv(0, 0, 0, 0, 0, 0, 0, 0), o(1, 0, 0, 0, 0, 0, 0, 3'd0), "mr_fetch");

        foreach (tv[i]) step(tv[i].in, tv[i].exp, tv[i].nm);

        // Random instruction streams: each instruction expands into its
        // fetch/decode/exec/mem/wb timeline; unused inputs carry noise.
        step(iv(1, 0, 0, 0, 0, 0, 0, 0), zero_o, "rnd_rst");
        for (int n = 0; n < 80; n++) begin
            int   kind;
            int   iw;
            int   dw;
            logic ld;
            logic sto;
            logic rw;
            logic tk;
            kind = $urandom_range(0, 3);
            iw   = $urandom_range(0, 3);
            dw   = $urandom_range(0, 3);
            rw   = rb();
            tk   = rb();
            ld   = (kind == 2);
            sto  = (kind == 3);
            for (int k = 0; k <= iw; k++)
                step(iv(0, k == iw, rb(), rb(), rb(), rb(), rb(), rb()),
                     o(1, k == iw, 0, 0, 0, 0, 0, 3'd0), "rnd_fetch");
            step(iv(0, rb(), rb(), ld, sto, 0, rw, tk),
                 o(0, 0, 0, 0, 0, 0, 0, 3'd1), "rnd_decode");
            step(iv(0, rb(), rb(), ld, sto, 0, rw, tk),
                 o(0, 0, 0, 0, 0, 0, 0, 3'd2), "rnd_exec");
            if (ld || sto) begin
                for (int k = 0; k <= dw; k++)
                    step(iv(0, rb(), k == dw, ld, sto, 0, rw, tk),
                         o(0, 0, 1, sto, 0, sto && (k == dw), 0, 3'd3), "rnd_mem");
            end
            if (!sto)
                step(iv(0, rb(), rb(), ld, sto, 0, rw, tk),
                     o(0, 0, 0, 0, rw, 1, tk, 3'd4), "rnd_wb");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
